// File: rtl/hp_pkg.sv
// Shared definitions for the HP bar: transparent colour, heart artwork and blink FSM states.
package hp_pkg;

    localparam logic [7:0] TRANSPARENT = 8'hFF;

    localparam int BMP_W = 16;
    localparam int BMP_H = 16;

    localparam logic [7:0] HEART_RED  = 8'hE0;
    localparam logic [7:0] HEART_PINK = 8'hF6;

    // Bit 15 of each row is the leftmost pixel.
    localparam logic [0:BMP_H-1][BMP_W-1:0] HEART_MASK = {
        16'b0000000000000000,
        16'b0011100000011100,
        16'b0111110000111110,
        16'b1111111001111111,
        16'b1111111111111111,
        16'b1111111111111111,
        16'b1111111111111111,
        16'b0111111111111110,
        16'b0011111111111100,
        16'b0001111111111000,
        16'b0000111111110000,
        16'b0000011111100000,
        16'b0000001111000000,
        16'b0000000110000000,
        16'b0000000000000000,
        16'b0000000000000000
    };

    // Small specular highlight on the left lobe; always a subset of the mask.
    localparam logic [0:BMP_H-1][BMP_W-1:0] HEART_HILITE = {
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0011000000000000,
        16'b0110000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000,
        16'b0000000000000000
    };

    typedef logic [0:BMP_H-1][0:BMP_W-1][7:0] heart_bmp_t;

    function automatic heart_bmp_t build_heart();
        heart_bmp_t bmp;
        for (int y = 0; y < BMP_H; y++) begin
            for (int x = 0; x < BMP_W; x++) begin
                if (HEART_HILITE[y][BMP_W-1-x])
                    bmp[y][x] = HEART_PINK;
                else if (HEART_MASK[y][BMP_W-1-x])
                    bmp[y][x] = HEART_RED;
                else
                    bmp[y][x] = 8'h00;
            end
        end
        return bmp;
    endfunction

    // Entry value 0 marks an empty (see-through) bitmap pixel.
    localparam heart_bmp_t HEART_BMP = build_heart();

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } blink_state_t;

endpackage

// File: rtl/heart_bitmap.sv
// Combinational heart artwork lookup; offsets outside the artwork return 0 (empty).
module heart_bitmap
    import hp_pkg::*;
(
    input  logic [10:0] i_offset_x,
    input  logic [10:0] i_offset_y,
    output logic [7:0]  o_color
);

    always_comb begin
        o_color = 8'h00;
        if ((i_offset_x < 11'(BMP_W)) && (i_offset_y < 11'(BMP_H)))
            o_color = HEART_BMP[i_offset_y[3:0]][i_offset_x[3:0]];
    end

endmodule

// File: rtl/hp_bar_display.sv
// Row of heart slots showing current HP, with a blink on the most recently lost heart.
//   state | meaning
//   IDLE  | no blink; slots below hpCount are solid
//   BLINK | slot blinkIdx toggles every 4 frames until BLINK_FRAMES frames elapse
module hp_bar_display
    import hp_pkg::*;
#(
    parameter int MAX_HP       = 5,
    parameter int START_HP     = 3,
    parameter int TOP_LEFT_X   = 16,
    parameter int TOP_LEFT_Y   = 8,
    parameter int HEART_W      = 16,
    parameter int HEART_H      = 16,
    parameter int GAP          = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        decrease,
    input  logic        increase,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [3:0]  hpCount,
    output logic        hpEmpty,
    output logic        hpEmptyPulse
);

    localparam logic [10:0] SLOT_Y0 = 11'(TOP_LEFT_Y);
    localparam logic [10:0] SLOT_Y1 = 11'(TOP_LEFT_Y + HEART_H - 1);

    function automatic logic [10:0] slot_x0(input int i);
        return 11'(TOP_LEFT_X + i * (HEART_W + GAP));
    endfunction

    logic [3:0]   r_hp;
    logic         r_empty_pulse;
    blink_state_t r_state, w_state_nxt;
    logic [5:0]   r_frame_cnt, w_frame_nxt;
    logic [3:0]   r_blink_idx, w_idx_nxt;
    logic         r_draw;
    logic [7:0]   r_rgb;

    logic              w_dec_eff;
    logic              w_inc_eff;
    logic              w_blink_on;
    logic [MAX_HP-1:0] w_visible;
    logic              w_in_y;
    logic              w_hit;
    logic [10:0]       w_off_x;
    logic [10:0]       w_off_y;
    logic [7:0]        w_color;
    logic              w_opaque;

    // Simultaneous decrease/increase cancel out entirely.
    assign w_dec_eff = decrease && !increase && (r_hp != 4'd0);
    assign w_inc_eff = increase && !decrease && (r_hp != 4'(MAX_HP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hp          <= 4'(START_HP);
            r_empty_pulse <= 1'b0;
        end else begin
            r_empty_pulse <= w_dec_eff && (r_hp == 4'd1);
            if (w_dec_eff)
                r_hp <= r_hp - 4'd1;
            else if (w_inc_eff)
                r_hp <= r_hp + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_frame_cnt <= 6'd0;
            r_blink_idx <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_blink_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame_cnt;
        w_idx_nxt   = r_blink_idx;
        case (r_state)
            IDLE: begin
                if (w_dec_eff) begin
                    w_state_nxt = BLINK;
                    w_idx_nxt   = r_hp - 4'd1;
                    w_frame_nxt = 6'd0;
                end
            end
            BLINK: begin
                if (w_dec_eff) begin
                    w_idx_nxt   = r_hp - 4'd1;
                    w_frame_nxt = 6'd0;
                end else if (w_inc_eff) begin
                    // The refilled slot is the one that was blinking.
                    w_state_nxt = IDLE;
                    w_frame_nxt = 6'd0;
                end else if (startOfFrame) begin
                    if (r_frame_cnt == 6'(BLINK_FRAMES - 1)) begin
                        w_state_nxt = IDLE;
                        w_frame_nxt = 6'd0;
                    end else begin
                        w_frame_nxt = r_frame_cnt + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_frame_nxt = 6'd0;
            end
        endcase
    end

    assign w_blink_on = (r_state == BLINK) && !r_frame_cnt[2];

    always_comb begin
        w_visible = '0;
        for (int i = 0; i < MAX_HP; i++)
            w_visible[i] = (4'(i) < r_hp) || (w_blink_on && (r_blink_idx == 4'(i)));
    end

    // One comparator pair per slot; slots never overlap so at most one hits.
    always_comb begin
        w_hit   = 1'b0;
        w_off_x = 11'd0;
        w_in_y  = (pixelY >= SLOT_Y0) && (pixelY <= SLOT_Y1);
        for (int i = 0; i < MAX_HP; i++) begin
            if (w_in_y && w_visible[i] &&
                (pixelX >= slot_x0(i)) &&
                (pixelX <= slot_x0(i) + 11'(HEART_W - 1))) begin
                w_hit   = 1'b1;
                w_off_x = pixelX - slot_x0(i);
            end
        end
    end

    assign w_off_y = pixelY - SLOT_Y0;

    heart_bitmap u_heart_bitmap (
        .i_offset_x (w_off_x),
        .i_offset_y (w_off_y),
        .o_color    (w_color)
    );

    assign w_opaque = w_hit && (w_color != 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_draw <= 1'b0;
            r_rgb  <= TRANSPARENT;
        end else begin
            r_draw <= w_opaque;
            r_rgb  <= w_opaque ? w_color : TRANSPARENT;
        end
    end

    assign drawingRequest = r_draw;
    assign RGBout         = r_rgb;
    assign hpCount        = r_hp;
    assign hpEmpty        = (r_hp == 4'd0);
    assign hpEmptyPulse   = r_empty_pulse;

endmodule
